// File: rtl/phmm_ctrl_pkg.sv
// Shared types and helpers for the Pair-HMM systolic array controller.
package phmm_ctrl_pkg;

  localparam int unsigned NUM_PE_DEFAULT = 8;
  localparam int unsigned LEN_W_DEFAULT  = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_ADVANCE = 2'd2,
    ST_FINISH  = 2'd3
  } ctrl_state_e;

  function automatic logic cfg_legal(input int unsigned read_len,
                                     input int unsigned hap_len,
                                     input int unsigned num_pe,
                                     input int unsigned len_w);
    return (read_len >= 32'd1) && (read_len <= num_pe) &&
           (hap_len >= 32'd1) && (hap_len < (32'd1 << len_w));
  endfunction

endpackage

// File: rtl/wavefront_mask.sv
// Diagonal wavefront enable and first-column traceback select for each PE.
module wavefront_mask #(
  parameter int unsigned NUM_PE = 8,
  parameter int unsigned LEN_W  = 8,
  parameter int unsigned RL_W   = $clog2(NUM_PE + 1)
) (
  input  logic              active_i,
  input  logic [LEN_W:0]    step_i,
  input  logic [RL_W-1:0]   read_len_i,
  input  logic [LEN_W-1:0]  hap_len_i,
  output logic [NUM_PE-1:0] enable_o,
  output logic [NUM_PE-1:0] tb_special_o
);

  int unsigned s;
  int unsigned rl;
  int unsigned hl;

  always_comb begin
    enable_o     = '0;
    tb_special_o = '0;
    s  = 32'(step_i);
    rl = 32'(read_len_i);
    hl = 32'(hap_len_i);
    for (int unsigned i = 0; i < NUM_PE; i++) begin
      if (active_i && (i < rl) && (s >= i) && ((s - i) < hl)) begin
        enable_o[i]     = 1'b1;
        tb_special_o[i] = (s == i);
      end
    end
  end

endmodule

// File: rtl/systolic_array_ctrl.sv
// Wavefront scheduler: steps the diagonal across the PE array, one advance per step.
module systolic_array_ctrl
  import phmm_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PE = NUM_PE_DEFAULT,
  parameter int unsigned LEN_W  = LEN_W_DEFAULT
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [$clog2(NUM_PE+1)-1:0]  read_len,
  input  logic [LEN_W-1:0]             hap_len,
  input  logic [NUM_PE-1:0]            pe_done,
  output logic [NUM_PE-1:0]            pe_enable,
  output logic [NUM_PE-1:0]            pe_set_tb_special,
  output logic                         pe_advance,
  output logic [LEN_W-1:0]             hap_idx,
  output logic                         busy,
  output logic                         col_valid,
  output logic [LEN_W-1:0]             col_idx,
  output logic                         job_done,
  output logic                         cfg_err
);

  localparam int unsigned RL_W = $clog2(NUM_PE + 1);
  localparam int unsigned SW   = LEN_W + 1;

  ctrl_state_e      state_q, state_d;
  logic [SW-1:0]    step_q, step_d;
  logic [RL_W-1:0]  read_len_q, read_len_d;
  logic [LEN_W-1:0] hap_len_q, hap_len_d;
  logic             col_valid_q, col_valid_d;
  logic [LEN_W-1:0] col_idx_q, col_idx_d;
  logic             cfg_err_q, cfg_err_d;

  logic          active;
  logic [SW-1:0] rl_ext, hl_ext, rl_m1, total_m1, col_ext;
  logic          last_step, last_pe_on, all_done, legal;

  assign active = (state_q == ST_COMPUTE) || (state_q == ST_ADVANCE);

  wavefront_mask #(
    .NUM_PE (NUM_PE),
    .LEN_W  (LEN_W),
    .RL_W   (RL_W)
  ) u_mask (
    .active_i     (active),
    .step_i       (step_q),
    .read_len_i   (read_len_q),
    .hap_len_i    (hap_len_q),
    .enable_o     (pe_enable),
    .tb_special_o (pe_set_tb_special)
  );

  // Last active PE column = step - (read_len-1); valid while inside the haplotype.
  assign rl_ext     = SW'(read_len_q);
  assign hl_ext     = {1'b0, hap_len_q};
  assign rl_m1      = rl_ext - SW'(1);
  assign total_m1   = rl_ext + hl_ext - SW'(2);
  assign col_ext    = step_q - rl_m1;
  assign last_step  = (step_q == total_m1);
  assign last_pe_on = (step_q >= rl_m1) && (col_ext < hl_ext);
  assign all_done   = &(pe_done | ~pe_enable);
  assign legal      = cfg_legal(32'(read_len), 32'(hap_len), NUM_PE, LEN_W);

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    read_len_d  = read_len_q;
    hap_len_d   = hap_len_q;
    col_valid_d = 1'b0;
    col_idx_d   = col_idx_q;
    cfg_err_d   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (legal) begin
            read_len_d = read_len;
            hap_len_d  = hap_len;
            step_d     = '0;
            state_d    = ST_COMPUTE;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_COMPUTE: begin
        if (all_done) state_d = ST_ADVANCE;
      end
      ST_ADVANCE: begin
        if (last_pe_on) begin
          col_valid_d = 1'b1;
          col_idx_d   = col_ext[LEN_W-1:0];
        end
        if (last_step) begin
          state_d = ST_FINISH;
        end else begin
          step_d  = step_q + SW'(1);
          state_d = ST_COMPUTE;
        end
      end
      ST_FINISH: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      step_q      <= '0;
      read_len_q  <= '0;
      hap_len_q   <= '0;
      col_valid_q <= 1'b0;
      col_idx_q   <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      step_q      <= step_d;
      read_len_q  <= read_len_d;
      hap_len_q   <= hap_len_d;
      col_valid_q <= col_valid_d;
      col_idx_q   <= col_idx_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign pe_advance = (state_q == ST_ADVANCE);
  assign busy       = (state_q != ST_IDLE);
  assign job_done   = (state_q == ST_FINISH);
  assign hap_idx    = (active && (step_q < hl_ext)) ? step_q[LEN_W-1:0] : '0;
  assign col_valid  = col_valid_q;
  assign col_idx    = col_idx_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: doc/systolic_array_ctrl.md
# systolic_array_ctrl

Wavefront scheduler for the Pair-HMM systolic array of `processing_element_hlf` instances. The block accepts one read/haplotype alignment job and sequences the diagonal wavefront across the array. Each step it drives per-PE `enable` and `set_tb_special`, waits until every enabled PE reports `done`, then broadcasts a one-cycle `advance`. It sits between the job loader (sequence/probability buffers) and the PE array, and flags each column result leaving the last active PE.

## Interface
- `NUM_PE`, default 8: number of PEs in the array, i.e. maximum read length.
- `LEN_W`, default 8: width of the haplotype length and column index.
- `clk  in  1`: clock.
- `reset  in  1`: synchronous, active-high reset.
- `start  in  1`: job request, sampled only in IDLE.
- `read_len  in  $clog2(NUM_PE+1)`: active PEs, legal range 1..NUM_PE.
- `hap_len  in  LEN_W`: haplotype columns, legal range 1..2^LEN_W-1.
- `pe_done  in  NUM_PE`: per-PE `done` vector.
- `pe_enable  out  NUM_PE`: per-PE `enable`.
- `pe_set_tb_special  out  NUM_PE`: per-PE `set_tb_special`.
- `pe_advance  out  1`: broadcast `advance`.
- `hap_idx  out  LEN_W`: haplotype base index to present to PE0 this step.
- `busy  out  1`: high whenever the block is not in IDLE.
- `col_valid  out  1`: one-cycle pulse; the last active PE's `pe_vals_out` holds the result for column `col_idx`.
- `col_idx  out  LEN_W`: column index qualified by `col_valid`.
- `job_done  out  1`: one-cycle pulse at job end.
- `cfg_err  out  1`: one-cycle pulse when `start` carries an illegal configuration.

## Operation
- States: IDLE, COMPUTE, ADVANCE, FINISH.
- **IDLE**
  - On `start` with a legal configuration: latch `read_len`/`hap_len`, clear `step`, go to COMPUTE.
  - On `start` with an illegal configuration: pulse `cfg_err`, stay in IDLE.
- **Step count:** `total = read_len + hap_len - 1`; `step` runs 0..total-1, width LEN_W+1.
- **Enable mask:** `pe_enable[i] = (i < read_len) && (step >= i) && (step - i < hap_len)`. The mask is driven in both COMPUTE and ADVANCE, and is 0 in IDLE and FINISH.
- **Traceback select:** `pe_set_tb_special[i] = pe_enable[i] && (step == i)`, i.e. the PE's first column.
- **Haplotype index:** `hap_idx = step` while `step < hap_len`, otherwise 0.
- **COMPUTE:** stay until `(pe_done | ~pe_enable) == all-ones`, then go to ADVANCE. `pe_done` bits of disabled PEs are ignored.
- **ADVANCE:** one cycle with `pe_advance=1`, and the mask is still held so enabled PEs latch their results.
  - If `step == total-1`, go to FINISH.
  - Otherwise increment `step` and return to COMPUTE.
- **Column output:** when ADVANCE occurs with `pe_enable[read_len-1]` set, assert `col_valid` on the next cycle with `col_idx = step - (read_len-1)`.
- **FINISH:** one cycle; pulse `job_done`, go to IDLE.
- **Boundary conditions**
  - `start` while busy is ignored; no error is raised.
  - `reset` in any state returns to IDLE on the next edge and drops all outputs that edge. No `pe_advance` is issued after reset.
  - `read_len=1, hap_len=1`: exactly one step.
  - The final `col_valid` for the last column coincides with the FINISH cycle.

## Timing
- **Reset values:** state IDLE, `step=0`, and every output 0.
- **Start to first step:** `start` high at edge k gives COMPUTE with `step=0` and the mask valid from cycle k+1.
- **`done` to `advance`:** all-done seen in cycle c gives `pe_advance` in cycle c+1. `pe_done` is sampled registered-free and must fall after the advance, which the PE tree reset guarantees.
- **Per-step cost:** `D_step + 1` cycles, where `D_step` is the COMPUTE dwell.
- **Job latency:** `1 + Σ(D_step+1) + 1` cycles from `start` to `job_done`.
- **`col_valid`:** one cycle after the matching ADVANCE.
- **Pulse widths:** `job_done`, `col_valid`, `cfg_err` and `pe_advance` are each exactly one cycle.

## Structure
- **Shared package `phmm_ctrl_pkg`:**
  - `ctrl_state_e` enum.
  - Default `NUM_PE`/`LEN_W` localparams.
  - Config-legality function.
- **Sub-module `wavefront_mask`:** combinational, producing `pe_enable`/`pe_set_tb_special` from `step`, `read_len` and `hap_len`. It is instantiated once.
- **Top-level registers:** FSM, `step` counter, latched config, and the `col_valid` pipeline register.

## Test plan
- **Minimal job:** `read_len=1, hap_len=1`, `pe_done[0]` returned 3 cycles after enable → one `pe_advance`, `col_valid` with `col_idx=0`, then `job_done`; total 6 cycles from `start`.
- **Full wavefront:** `read_len=4, hap_len=3`, all dones after 5 cycles → 6 steps with masks 0001, 0011, 0111, 1110, 1100, 1000; `pe_set_tb_special` one-hot on diagonal steps 0..3; `col_valid` with `col_idx` 0, 1, 2 after steps 3, 4, 5.
- **Staggered dones:** PE2 done 10 cycles late → no `pe_advance` until PE2 done; disabled PE5 holding `done=0` never blocks.
- **Illegal config:** `start` with `read_len=0`, `read_len=NUM_PE+1` or `hap_len=0` → `cfg_err` pulse, `busy` stays 0.
- **Start while busy:** `start` asserted mid-job → ignored; latched config and `step` unchanged.
- **Reset mid-job:** `reset` asserted in COMPUTE at step 2 → next cycle IDLE with all outputs 0; a fresh `start` then runs normally from `step=0`.
